// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
// Bundles the instruction word fields, the ALU flag feedback, the memory
// req/ack handshakes and every datapath control line driven by the
// multi-cycle controller.
//   master : controller side (drives controls and requests, receives
//            instruction fields, flags and acks)
//   slave  : datapath / memory side
// Parameter RA_W : destination register address width.
// ---------------------------------------------------------------------------
interface multicycle_controller_if #(
  parameter int unsigned RA_W = 4
);
  // Instruction fields (from the instruction register) and feedback
  logic [3:0]      cmd;
  logic [1:0]      cond;
  logic [RA_W-1:0] ra;
  logic [3:0]      alu_flags;
  logic            imem_ack;
  logic            dmem_ack;

  // Controls and requests
  logic            imem_req;
  logic            ir_write;
  logic            pc_inc;
  logic            pc_load;
  logic            reg_write;
  logic            reg_src;
  logic            alu_src;
  logic            shift_dir;
  logic [2:0]      alu_ctrl;
  logic [1:0]      mem_to_reg;
  logic            dmem_req;
  logic            dmem_we;
  logic [3:0]      flags;
  logic            illegal;
  logic            bus_err;

  modport master (
    input  cmd, cond, ra, alu_flags, imem_ack, dmem_ack,
    output imem_req, ir_write, pc_inc, pc_load, reg_write, reg_src,
           alu_src, shift_dir, alu_ctrl, mem_to_reg, dmem_req, dmem_we,
           flags, illegal, bus_err
  );

  modport slave (
    output cmd, cond, ra, alu_flags, imem_ack, dmem_ack,
    input  imem_req, ir_write, pc_inc, pc_load, reg_write, reg_src,
           alu_src, shift_dir, alu_ctrl, mem_to_reg, dmem_req, dmem_we,
           flags, illegal, bus_err
  );
endinterface

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Moore sequencer for the multi-cycle datapath:
//   START -> FETCH -> DECODE -> {EXEC | MEM} -> [WB] -> FETCH
// Instruction and data memory use req/ack handshakes; a request that waits
// WAIT_LIMIT cycles without ack is aborted with a one-cycle bus_err pulse
// (FETCH retries, MEM abandons the instruction). A clocked flag register is
// loaded only by CMP in EXEC and drives per-instruction conditional execution.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    multicycle_controller_if.master (instruction fields, alu_flags,
//          acks in; datapath controls, requests, flags, illegal, bus_err out)
//
// Parameters:
//   RA_W        destination address width; all-ones address is the PC
//   WAIT_LIMIT  req cycles without ack before abort, 1..255
//
// cmd/cond/ra come from the instruction register and are stable from DECODE
// until the instruction completes.
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter int unsigned RA_W       = 4,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_controller_if.master   bus
);

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_ORR = 4'd3,
    OP_LSL = 4'd4,
    OP_LSR = 4'd5,
    OP_CMP = 4'd6,
    OP_STR = 4'd7,
    OP_LDR = 4'd8
  } op_t;

  // Registered control outputs, computed from the next state so that each
  // state's controls are glitch-free from the first cycle of that state.
  typedef struct packed {
    logic       imem_req;
    logic       pc_load;
    logic       reg_write;
    logic       reg_src;
    logic       alu_src;
    logic       shift_dir;
    logic [2:0] alu_ctrl;
    logic [1:0] mem_to_reg;
    logic       dmem_req;
    logic       dmem_we;
    logic       bus_err;
  } ctl_t;

  // Timeout fires at the edge closing the WAIT_LIMIT-th un-acked req cycle.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;
  ctl_t       ctl_q, ctl_d;

  logic cmd_legal;
  logic cond_ok;
  logic is_mem_op;
  logic is_str;
  logic ra_is_pc;
  logic timeout;

  assign cmd_legal = (bus.cmd <= 4'd8);
  assign is_mem_op = (bus.cmd == OP_STR) || (bus.cmd == OP_LDR);
  assign is_str    = (bus.cmd == OP_STR);
  assign ra_is_pc  = (bus.ra == {RA_W{1'b1}});
  assign timeout   = (cnt_q == WAIT_LAST);

  // Condition evaluated against the registered flags {N,Z,C,V}.
  always_comb begin
    unique case (bus.cond)
      2'b00:   cond_ok = 1'b1;
      2'b01:   cond_ok = flags_q[2];
      2'b10:   cond_ok = !flags_q[2];
      default: cond_ok = flags_q[3] ^ flags_q[0];
    endcase
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    flags_d = flags_q;
    ctl_d   = '0;

    // Next-state transitions
    case (state_q)
      S_START: state_d = S_FETCH;

      S_FETCH: begin
        if (bus.imem_ack) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          ctl_d.bus_err = 1'b1;       // retry: stay in FETCH, counter cleared
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_DECODE: begin
        if (!cmd_legal || !cond_ok) state_d = S_FETCH;
        else if (is_mem_op)         state_d = S_MEM;
        else                        state_d = S_EXEC;
      end

      S_EXEC: begin
        if (bus.cmd == OP_CMP) begin
          flags_d = bus.alu_flags;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        if (bus.dmem_ack) begin
          state_d = is_str ? S_FETCH : S_WB;
        end else if (timeout) begin
          ctl_d.bus_err = 1'b1;       // instruction abandoned, no write
          state_d       = S_FETCH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_WB:    state_d = S_FETCH;

      default: state_d = S_START;
    endcase

    // Controls for the state being entered
    case (state_d)
      S_FETCH: ctl_d.imem_req = 1'b1;

      S_EXEC: begin
        case (bus.cmd)
          OP_ADD: begin ctl_d.alu_ctrl = 3'b000; ctl_d.mem_to_reg = 2'b01; end
          OP_SUB: begin ctl_d.alu_ctrl = 3'b001; ctl_d.mem_to_reg = 2'b01; end
          OP_AND: begin ctl_d.alu_ctrl = 3'b010; ctl_d.mem_to_reg = 2'b01; end
          OP_ORR: begin ctl_d.alu_ctrl = 3'b011; ctl_d.mem_to_reg = 2'b01; end
          OP_LSL: begin ctl_d.alu_src  = 1'b1;   ctl_d.mem_to_reg = 2'b10; end
          OP_LSR: begin
            ctl_d.alu_src    = 1'b1;
            ctl_d.shift_dir  = 1'b1;
            ctl_d.mem_to_reg = 2'b10;
          end
          OP_CMP: begin ctl_d.alu_ctrl = 3'b001; ctl_d.reg_src = 1'b1; end
          default: ;
        endcase
      end

      S_MEM: begin
        ctl_d.alu_src  = 1'b1;        // base + immediate address add
        ctl_d.dmem_req = 1'b1;
        ctl_d.dmem_we  = is_str;
        ctl_d.reg_src  = is_str;
      end

      S_WB: begin
        ctl_d.mem_to_reg = ctl_q.mem_to_reg;  // selected in EXEC/MEM, held
        ctl_d.pc_load    = ra_is_pc;
        ctl_d.reg_write  = !ra_is_pc;
      end

      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_START;
      cnt_q   <= '0;
      flags_q <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      ctl_q   <= ctl_d;
    end
  end

  // ir_write/pc_inc must coincide with the accepting ack cycle, and illegal
  // must pulse during DECODE itself, so these three are decoded from state.
  assign bus.ir_write   = (state_q == S_FETCH) && bus.imem_ack;
  assign bus.pc_inc     = (state_q == S_FETCH) && bus.imem_ack;
  assign bus.illegal    = (state_q == S_DECODE) && !cmd_legal;

  assign bus.imem_req   = ctl_q.imem_req;
  assign bus.pc_load    = ctl_q.pc_load;
  assign bus.reg_write  = ctl_q.reg_write;
  assign bus.reg_src    = ctl_q.reg_src;
  assign bus.alu_src    = ctl_q.alu_src;
  assign bus.shift_dir  = ctl_q.shift_dir;
  assign bus.alu_ctrl   = ctl_q.alu_ctrl;
  assign bus.mem_to_reg = ctl_q.mem_to_reg;
  assign bus.dmem_req   = ctl_q.dmem_req;
  assign bus.dmem_we    = ctl_q.dmem_we;
  assign bus.bus_err    = ctl_q.bus_err;
  assign bus.flags      = flags_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
// Directed bench: each cycle the full control vector is compared against a
// hand-built expected value. Inputs change at posedge+2, outputs are sampled
// at posedge+3.
// Control vector bit order (MSB..LSB):
//   imem_req ir_write pc_inc pc_load reg_write reg_src alu_src shift_dir
//   alu_ctrl[2:0] mem_to_reg[1:0] dmem_req dmem_we illegal bus_err
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam int unsigned RA_W       = 4;
  localparam int unsigned WAIT_LIMIT = 15;

  localparam logic [16:0] IREQ  = 17'h1 << 16;
  localparam logic [16:0] IRW   = 17'h1 << 15;
  localparam logic [16:0] PCI   = 17'h1 << 14;
  localparam logic [16:0] PCL   = 17'h1 << 13;
  localparam logic [16:0] RW    = 17'h1 << 12;
  localparam logic [16:0] RS    = 17'h1 << 11;
  localparam logic [16:0] ASRC  = 17'h1 << 10;
  localparam logic [16:0] SHD   = 17'h1 << 9;
  localparam logic [16:0] DREQ  = 17'h1 << 3;
  localparam logic [16:0] DWE   = 17'h1 << 2;
  localparam logic [16:0] ILL   = 17'h1 << 1;
  localparam logic [16:0] BERR  = 17'h1;

  logic clk;
  logic rst_n;

  multicycle_controller_if #(.RA_W(RA_W)) bus ();

  multicycle_controller #(
    .RA_W       (RA_W),
    .WAIT_LIMIT (WAIT_LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] ctl;
  assign ctl = {bus.imem_req, bus.ir_write, bus.pc_inc, bus.pc_load,
                bus.reg_write, bus.reg_src, bus.alu_src, bus.shift_dir,
                bus.alu_ctrl, bus.mem_to_reg, bus.dmem_req, bus.dmem_we,
                bus.illegal, bus.bus_err};

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [16:0] ac(input logic [2:0] v);
    return {8'd0, v, 6'd0};
  endfunction

  function automatic logic [16:0] m2r(input logic [1:0] v);
    return {11'd0, v, 4'd0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Check the control vector in the current cycle, then advance one cycle.
  task automatic expect_cycle(input string tag, input logic [16:0] exp);
    #1;
    check(tag, 32'(ctl), 32'(exp));
    @(posedge clk);
    #2;
  endtask

  // FETCH cycle with an immediate ack.
  task automatic fetch(input string tag);
    bus.imem_ack = 1'b1;
    expect_cycle(tag, IREQ | IRW | PCI);
    bus.imem_ack = 1'b0;
  endtask

  task automatic set_instr(input logic [3:0] c, input logic [1:0] cd,
                           input logic [RA_W-1:0] r);
    bus.cmd  = c;
    bus.cond = cd;
    bus.ra   = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.cmd       = 4'd0;
    bus.cond      = 2'b00;
    bus.ra        = 4'd3;
    bus.alu_flags = 4'b0000;
    bus.imem_ack  = 1'b0;
    bus.dmem_ack  = 1'b0;

    // Reset state
    #2;
    check("reset_ctl", 32'(ctl), 32'h0);
    check("reset_flags", 32'(bus.flags), 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // START lasts one cycle; an ack without a request is ignored.
    bus.imem_ack = 1'b1;
    expect_cycle("start_ack_ignored", 17'h0);
    bus.imem_ack = 1'b0;

    // ADD ra=3: FETCH DECODE EXEC WB
    set_instr(4'd0, 2'b00, 4'd3);
    fetch("add_fetch");
    expect_cycle("add_decode", 17'h0);
    expect_cycle("add_exec", ac(3'b000) | m2r(2'b01));
    expect_cycle("add_wb", m2r(2'b01) | RW);

    // CMP loads flags at the end of EXEC
    set_instr(4'd6, 2'b00, 4'd0);
    bus.alu_flags = 4'b0100;
    fetch("cmp_fetch");
    expect_cycle("cmp_decode", 17'h0);
    expect_cycle("cmp_exec", ac(3'b001) | RS);
    check("cmp_flags", 32'(bus.flags), 32'h4);
    bus.alu_flags = 4'b1001;  // must not be captured by non-CMP instructions

    // SUB EQ with Z=1 executes
    set_instr(4'd1, 2'b01, 4'd3);
    fetch("sub_eq_fetch");
    expect_cycle("sub_eq_decode", 17'h0);
    expect_cycle("sub_eq_exec", ac(3'b001) | m2r(2'b01));
    expect_cycle("sub_eq_wb", m2r(2'b01) | RW);
    check("sub_eq_flags_kept", 32'(bus.flags), 32'h4);

    // SUB NE with Z=1 is annulled: DECODE -> FETCH
    set_instr(4'd1, 2'b10, 4'd3);
    fetch("sub_ne_fetch");
    expect_cycle("sub_ne_decode", 17'h0);
    #1;
    check("sub_ne_annul_fetch", 32'(ctl), 32'(IREQ));

    // Annulled CMP leaves flags untouched
    set_instr(4'd6, 2'b10, 4'd0);
    fetch("cmp_annul_fetch");
    expect_cycle("cmp_annul_decode", 17'h0);
    #1;
    check("cmp_annul_next", 32'(ctl), 32'(IREQ));
    check("cmp_annul_flags", 32'(bus.flags), 32'h4);

    // LDR with dmem_ack in the 4th request cycle: 7 cycles total
    set_instr(4'd8, 2'b00, 4'd5);
    fetch("ldr_fetch");
    expect_cycle("ldr_decode", 17'h0);
    for (int i = 0; i < 3; i++) expect_cycle("ldr_mem_wait", ASRC | DREQ);
    bus.dmem_ack = 1'b1;
    expect_cycle("ldr_mem_ack", ASRC | DREQ);
    bus.dmem_ack = 1'b0;
    expect_cycle("ldr_wb", m2r(2'b00) | RW);

    // ADD to the PC address is a branch
    set_instr(4'd0, 2'b00, 4'd15);
    fetch("br_fetch");
    expect_cycle("br_decode", 17'h0);
    expect_cycle("br_exec", ac(3'b000) | m2r(2'b01));
    expect_cycle("br_wb", m2r(2'b01) | PCL);

    // LSR selects immediate operand and shifter result
    set_instr(4'd5, 2'b00, 4'd2);
    fetch("lsr_fetch");
    expect_cycle("lsr_decode", 17'h0);
    expect_cycle("lsr_exec", ASRC | SHD | m2r(2'b10));
    expect_cycle("lsr_wb", m2r(2'b10) | RW);

    // STR with no dmem_ack: 15 request cycles, then bus_err in FETCH
    set_instr(4'd7, 2'b00, 4'd1);
    fetch("str_to_fetch");
    expect_cycle("str_to_decode", 17'h0);
    for (int i = 0; i < WAIT_LIMIT; i++)
      expect_cycle("str_to_mem", ASRC | DREQ | DWE | RS);
    expect_cycle("str_to_buserr", IREQ | BERR);

    // Illegal opcode pulses in DECODE
    set_instr(4'd12, 2'b00, 4'd1);
    fetch("ill_fetch");
    expect_cycle("ill_decode", ILL);

    // FETCH timeout: retry in FETCH with counter cleared
    for (int i = 0; i < WAIT_LIMIT; i++) expect_cycle("fetch_to_wait", IREQ);
    expect_cycle("fetch_to_buserr", IREQ | BERR);
    expect_cycle("fetch_retry", IREQ);

    // Reset asserted during MEM of STR
    set_instr(4'd7, 2'b00, 4'd1);
    fetch("rst_str_fetch");
    expect_cycle("rst_str_decode", 17'h0);
    #1;
    check("rst_str_mem", 32'(ctl), 32'(ASRC | DREQ | DWE | RS));
    rst_n        = 1'b0;
    bus.dmem_ack = 1'b1;
    #1;
    check("rst_async_ctl", 32'(ctl), 32'h0);
    check("rst_async_flags", 32'(bus.flags), 32'h0);
    @(posedge clk);
    #2;
    bus.dmem_ack = 1'b0;
    rst_n        = 1'b1;
    expect_cycle("rst_start", 17'h0);
    #1;
    check("rst_fetch", 32'(ctl), 32'(IREQ));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath controller; drives the same datapath (ALU, shifter, register file, data memory) over several cycles per instruction.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK through a Moore state machine.
- Adds req/ack handshakes to instruction and data memory with a bounded wait timeout.
- Adds a clocked flag register (replacing the old negedge-of-decode latch) and per-instruction conditional execution.

Parameters:
- RA_W, 4, destination register address width; the PC register is the all-ones address.
- WAIT_LIMIT, 15, maximum cycles a req may wait for ack before abort (must be 1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LSL, 5 LSR, 6 CMP, 7 STR, 8 LDR, 9-15 illegal
- cond  in  2  condition: 00 always, 01 EQ (Z), 10 NE (!Z), 11 LT (N!=V)
- ra  in  RA_W  destination register address
- alu_flags  in  4  {N,Z,C,V} from ALU, valid in EXEC
- imem_ack  in  1  instruction memory ack
- dmem_ack  in  1  data memory ack
- imem_req  out  1  instruction fetch request
- ir_write  out  1  latch instruction register
- pc_inc  out  1  PC <= PC+4
- pc_load  out  1  PC <= result (branch)
- reg_write  out  1  register file write enable
- reg_src  out  1  1 for STR/CMP second read port select
- alu_src  out  1  1 = immediate operand
- shift_dir  out  1  0 LSL, 1 LSR
- alu_ctrl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR
- mem_to_reg  out  2  01 ALU, 10 shifter, 00 data memory
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (qualifies dmem_req)
- flags  out  4  registered {N,Z,C,V}
- illegal  out  1  one-cycle pulse on illegal opcode
- bus_err  out  1  one-cycle pulse on handshake timeout

Behaviour:
- Reset (rst_n=0, asynchronous): state=START, flags=0, wait counter=0; all outputs 0. START lasts exactly one cycle, then FETCH.
- FETCH: imem_req=1. On imem_ack: ir_write=1 and pc_inc=1 in that same cycle, next state DECODE. Without ack, the wait counter increments. Once the counter reaches WAIT_LIMIT with no ack: bus_err pulses, counter clears, state stays in FETCH (retry).
- DECODE (1 cycle, no writes): compute cond against the registered flags.
  - Illegal cmd: illegal pulses, next FETCH.
  - cond false: annul, next FETCH, nothing written.
  - cmd 0-6: next EXEC.
  - cmd 7-8: next MEM.
- EXEC (1 cycle): alu_ctrl, alu_src and shift_dir driven.
  - ADD/SUB/AND/ORR: alu_src=0, mem_to_reg=01.
  - LSL/LSR: alu_src=1, mem_to_reg=10.
  - CMP: alu_ctrl=001, reg_src=1; flags<=alu_flags at the closing edge; next FETCH.
  - Others: next WB.
- MEM: alu_src=1, alu_ctrl=000 (address add), dmem_req=1; dmem_we=1 and reg_src=1 for STR.
  - On dmem_ack: STR goes to FETCH, LDR goes to WB with mem_to_reg=00.
  - Timeout rule is the same as FETCH, but the instruction is abandoned: bus_err pulses, next FETCH, no register write.
- WB (1 cycle): mem_to_reg held from EXEC/MEM.
  - ra all ones: pc_load=1, reg_write=0 (branch).
  - Otherwise: reg_write=1.
  - Next FETCH.
- Wait counter clears on every state change and on ack.
- Latency with zero-wait ack (ack in first req cycle):
  - ALU/shift: 4 cycles.
  - CMP: 3 cycles.
  - STR: 3 cycles.
  - LDR: 4 cycles.
  - Annulled/illegal: 2 cycles.
- Flags change only in EXEC of CMP. A CMP annulled by cond leaves flags untouched.
- An ack arriving while no req is asserted is ignored.
- Reset asserted mid-instruction aborts immediately: no write completes, and flags return to 0.

Test Plan:
- Reset release, ADD (cmd=0, cond=00, ra=3), acks immediate -> START, FETCH, DECODE, EXEC, WB; reg_write=1 only in cycle 5; mem_to_reg=01.
- CMP with alu_flags=0100, then SUB cond=01 -> flags=0100 after EXEC; SUB executes (reg_write in WB). Repeat with cond=10 -> annulled: DECODE->FETCH, no reg_write.
- LDR, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, then WB with mem_to_reg=00 and reg_write=1; total 7 cycles.
- ADD with ra=15 -> WB asserts pc_load=1 and reg_write=0.
- dmem_ack never asserted on STR, WAIT_LIMIT=15 -> bus_err pulse after 15 req cycles, next FETCH, no write. cmd=12 -> illegal pulse in DECODE.
- rst_n low during MEM of STR -> outputs 0 and flags 0 asynchronously; after release, START then FETCH.
